// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
// ---------------------------------------------------------------------------
// Shares the RTC multiplexed address/data bus between three requesters and
// runs one complete bus transaction per grant:
//   address phase (SET/STB/HLD) -> turnaround -> data phase (SET/STB/HLD) -> DONE.
// Port 0 = config write, port 1 = chrono write, port 2 = periodic read.
// Fixed priority port0 > port1 > port2. Requests are level signals and are
// sampled only while idle. A request dropped during a transaction does not
// abort that transaction.
//
// Optional feature macro: RTC_AGING_EN
//   defined   : after AGE_MAX consecutive port0/1 grants made while the read
//               request is pending, the next arbitration goes to port 2.
//   undefined : strict fixed priority; port 2 may starve.
//
// Handshake: req_*_i is a level request. gnt_o is one-hot and stays stable
// from the grant edge until the clock edge that leaves DONE. ack_o pulses for
// exactly one cycle (the DONE cycle); for a port2 transaction rdata_o is valid
// in that cycle and holds until the next port2 capture.
//
// Parameters : PH_CYC  clk cycles per bus phase (1..255)
//              AGE_MAX port0/1 grants tolerated while a read waits
// Ports      : clk, Reset (async, active-high)
//              req/addr/wdata for ports 0 and 1, req/addr for port 2
//              gnt_o, ack_o, rdata_o, busy_o                - requester side
//              cs_n_o, a_d_o, wr_n_o, rd_n_o, ad_out_o,
//              ad_oe_o, ad_in_i                             - RTC pin side
//              state_o                                      - FSM state (debug)
// All outputs are registered.
// ---------------------------------------------------------------------------
module rtc_bus_arbiter #(
    parameter int unsigned PH_CYC  = 8,
    parameter int unsigned AGE_MAX = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       req_wr_i,
    input  logic [7:0] addr_wr_i,
    input  logic [7:0] wdata_wr_i,
    input  logic       req_cr_i,
    input  logic [7:0] addr_cr_i,
    input  logic [7:0] wdata_cr_i,
    input  logic       req_rd_i,
    input  logic [7:0] addr_rd_i,
    output logic [2:0] gnt_o,
    output logic       ack_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       cs_n_o,
    output logic       a_d_o,
    output logic       wr_n_o,
    output logic       rd_n_o,
    output logic [7:0] ad_out_o,
    output logic       ad_oe_o,
    input  logic [7:0] ad_in_i,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR_SET, ADDR_STB, ADDR_HLD, TURN,
        DATA_SET, DATA_STB, DATA_HLD, DONE
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(PH_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rd_q, rd_d;
    logic [2:0] gnt_q, gnt_d;
    logic [2:0] win;
    logic       phase_end;
    logic       addr_ph, data_ph;

    assign phase_end = (cnt_q == PH_LAST);

    // Aging: force a port2 win once enough port0/1 grants went by while the
    // read request was waiting.
`ifdef RTC_AGING_EN
    localparam int unsigned AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
    logic [AGE_W-1:0] age_q;
    logic             age_hit;
    assign age_hit = (age_q == AGE_W'(AGE_MAX));

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            age_q <= '0;
        end else if (state_q == IDLE) begin
            if (!req_rd_i || win[2]) begin
                age_q <= '0;
            end else if ((win[0] || win[1]) && !age_hit) begin
                age_q <= age_q + 1'b1;
            end
        end
    end
`else
    logic age_hit;
    logic unused_age_max;
    assign age_hit        = 1'b0;
    assign unused_age_max = (AGE_MAX == 0);
`endif

    always_comb begin
        win = 3'b000;
        if (req_rd_i && age_hit) win = 3'b100;
        else if (req_wr_i)       win = 3'b001;
        else if (req_cr_i)       win = 3'b010;
        else if (req_rd_i)       win = 3'b100;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (win != 3'b000) begin
                    state_d = ADDR_SET;
                    cnt_d   = 8'd0;
                    gnt_d   = win;
                    rd_d    = win[2];
                    addr_d  = win[0] ? addr_wr_i  : (win[1] ? addr_cr_i  : addr_rd_i);
                    wdata_d = win[0] ? wdata_wr_i : (win[1] ? wdata_cr_i : 8'h00);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
            default: begin
                if (phase_end) begin
                    cnt_d = 8'd0;
                    case (state_q)
                        ADDR_SET: state_d = ADDR_STB;
                        ADDR_STB: state_d = ADDR_HLD;
                        ADDR_HLD: state_d = TURN;
                        TURN:     state_d = DATA_SET;
                        DATA_SET: state_d = DATA_STB;
                        DATA_STB: state_d = DATA_HLD;
                        default:  state_d = DONE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // Pin outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    assign addr_ph = (state_d == ADDR_SET) || (state_d == ADDR_STB) || (state_d == ADDR_HLD);
    assign data_ph = (state_d == DATA_SET) || (state_d == DATA_STB) || (state_d == DATA_HLD);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            gnt_q    <= 3'b000;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            rd_q     <= 1'b0;
            ack_o    <= 1'b0;
            busy_o   <= 1'b0;
            rdata_o  <= 8'h00;
            cs_n_o   <= 1'b1;
            a_d_o    <= 1'b1;
            wr_n_o   <= 1'b1;
            rd_n_o   <= 1'b1;
            ad_out_o <= 8'h00;
            ad_oe_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            ack_o    <= (state_d == DONE);
            busy_o   <= (state_d != IDLE);
            cs_n_o   <= !(addr_ph || data_ph);
            a_d_o    <= !addr_ph;
            wr_n_o   <= !((state_d == ADDR_STB) || ((state_d == DATA_STB) && !rd_d));
            // The bus is never driven while the RTC is being read.
            rd_n_o   <= !((state_d == DATA_STB) && rd_d);
            ad_oe_o  <= addr_ph || (data_ph && !rd_d);
            ad_out_o <= addr_ph ? addr_d : ((data_ph && !rd_d) ? wdata_d : 8'h00);
            if ((state_q == DATA_STB) && phase_end && rd_q) begin
                rdata_o <= ad_in_i;
            end
        end
    end

    assign gnt_o   = gnt_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
`timescale 1ns/1ps
module tb_rtc_bus_arbiter;
  localparam int PH      = 2;
  localparam int AGE_MAX = 4;
  localparam int W       = 19;   // {gnt[2:0], addr[7:0], data[7:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       Reset;
  logic       req_wr_i, req_cr_i, req_rd_i;
  logic [7:0] addr_wr_i, wdata_wr_i, addr_cr_i, wdata_cr_i, addr_rd_i;
  logic [2:0] gnt_o;
  logic       ack_o, busy_o, cs_n_o, a_d_o, wr_n_o, rd_n_o, ad_oe_o;
  logic [7:0] rdata_o, ad_out_o, ad_in_i;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.PH_CYC(PH), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .Reset(Reset),
    .req_wr_i(req_wr_i), .addr_wr_i(addr_wr_i), .wdata_wr_i(wdata_wr_i),
    .req_cr_i(req_cr_i), .addr_cr_i(addr_cr_i), .wdata_cr_i(wdata_cr_i),
    .req_rd_i(req_rd_i), .addr_rd_i(addr_rd_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .cs_n_o(cs_n_o), .a_d_o(a_d_o), .wr_n_o(wr_n_o), .rd_n_o(rd_n_o),
    .ad_out_o(ad_out_o), .ad_oe_o(ad_oe_o), .ad_in_i(ad_in_i), .state_o(state_o)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic sb_en = 1'b0;
  logic [7:0] rd_val = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // RTC read responder: the read value appears only in the last strobe cycle.
  initial begin
    int low_cnt;
    low_cnt = 0;
    ad_in_i = 8'h00;
    forever begin
      @(negedge clk);
      low_cnt = (rd_n_o == 1'b0) ? low_cnt + 1 : 0;
      ad_in_i = (low_cnt == PH) ? rd_val : ~rd_val;
    end
  end

  // ---------------- reference model ----------------
  // One arbitration decision over the set of pending ports.
  task automatic model_step(input logic [2:0] pend, inout int age, output int p);
    if (!pend[2]) age = 0;
    if (pend[0]) p = 0;
    else if (pend[1]) p = 1;
    else p = 2;
`ifdef RTC_AGING_EN
    if (pend[2] && age == AGE_MAX) p = 2;
`endif
    if (p == 2) age = 0;
    else if (pend[2]) age++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         in_txn = 1'b0;
  logic [W-1:0] cur;
  logic [2:0]   gseen;
  int n, a_stb, d_stb, r_stb, wl, rl, csl, bad;
  int idle_bad = 0;
  int proto_bad = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (Reset || !sb_en) begin
        in_txn = 1'b0;
      end else begin
        if (!rd_n_o && ad_oe_o) proto_bad++;
        if (!in_txn && gnt_o != 3'b000) begin
          if (exp_q.size() == 0) begin
            chk("grant_unexpected", 32'(gnt_o), 32'd0);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            chk("grant_order", 32'(gnt_o), 32'(cur[18:16]));
          end
          in_txn = 1'b1; gseen = gnt_o;
          n = 0; a_stb = 0; d_stb = 0; r_stb = 0; wl = 0; rl = 0; csl = 0; bad = 0;
        end
        if (in_txn) begin
          if (gnt_o !== gseen || busy_o !== 1'b1) bad++;
          if (!cs_n_o) csl++;
          if (!wr_n_o) wl++;
          if (!rd_n_o) rl++;
          if (!wr_n_o && !a_d_o && !cs_n_o && ad_oe_o && ad_out_o == cur[15:8]) a_stb++;
          if (!wr_n_o && a_d_o && !cs_n_o && ad_oe_o && ad_out_o == cur[7:0]) d_stb++;
          if (!rd_n_o && a_d_o && !cs_n_o && !ad_oe_o) r_stb++;
          if (ack_o) begin
            chk("ack_latency", n, 7 * PH);
            chk("cs_low_cycles", csl, 6 * PH);
            chk("addr_strobe", a_stb, PH);
            if (cur[18]) begin
              chk("read_strobe", r_stb, PH);
              chk("read_wr_n_low", wl, PH);
              chk("rdata", 32'(rdata_o), 32'(cur[7:0]));
            end else begin
              chk("data_strobe", d_stb, PH);
              chk("write_wr_n_low", wl, 2 * PH);
              chk("write_rd_n_low", rl, 0);
            end
            chk("gnt_busy_held", bad, 0);
            in_txn = 1'b0;
          end else if (n > 7 * PH + 4) begin
            chk("ack_timeout", n, 7 * PH);
            in_txn = 1'b0;
          end
          n++;
        end else if (ack_o || busy_o || !cs_n_o || !wr_n_o || !rd_n_o || ad_oe_o) begin
          idle_bad++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drop_port(input logic [2:0] g);
    if (g[0]) req_wr_i = 1'b0;
    if (g[1]) req_cr_i = 1'b0;
    if (g[2]) req_rd_i = 1'b0;
  endtask

  // Raise the ports in s together; each request is held until its ack
  // (or dropped 3 cycles after its grant when early is set).
  task automatic run_round(input logic [2:0] s, input logic early,
                           input logic [7:0] a0, input logic [7:0] d0,
                           input logic [7:0] a1, input logic [7:0] d1,
                           input logic [7:0] a2, input logic [7:0] r2);
    logic [7:0] av[3];
    logic [7:0] dv[3];
    logic [2:0] pend, pg, oh;
    int age, p, cyc, k;
    av[0] = a0; av[1] = a1; av[2] = a2;
    dv[0] = d0; dv[1] = d1; dv[2] = r2;
    age = 0;
    pend = s;
    while (pend != 3'b000) begin
      model_step(pend, age, p);
      oh = 3'b001 << p;
      exp_q.push_back({oh, av[p], dv[p]});
      pend[p] = 1'b0;
    end
    rd_val = r2;
    addr_wr_i = a0; wdata_wr_i = d0;
    addr_cr_i = a1; wdata_cr_i = d1;
    addr_rd_i = a2;
    req_wr_i = s[0]; req_cr_i = s[1]; req_rd_i = s[2];
    pend = s; cyc = 0; k = 0; pg = 3'b000;
    while (pend != 3'b000 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gnt_o != 3'b000 && pg == 3'b000) k = 0;
      else if (gnt_o != 3'b000) k++;
      if (early && gnt_o != 3'b000 && k == 3) drop_port(gnt_o);
      if (ack_o) begin
        drop_port(gnt_o);
        pend = pend & ~gnt_o;
      end
      pg = gnt_o;
    end
    if (pend != 3'b000) chk("round_timeout", 32'(pend), 32'd0);
    drop_port(3'b111);
    repeat (3) @(negedge clk);
  endtask

  // Hold req_wr and req_rd for nt transactions.
  task automatic run_hold(input int nt);
    logic [7:0] aw, dw, ar, rv;
    logic [2:0] oh;
    int age, p, cnt, cyc, rd_exp, rd_seen;
    aw = 8'($urandom); dw = 8'($urandom); ar = 8'($urandom); rv = 8'($urandom);
    age = 0; rd_exp = 0;
    for (int i = 0; i < nt; i++) begin
      model_step(3'b101, age, p);
      oh = 3'b001 << p;
      if (p == 2) rd_exp++;
      exp_q.push_back({oh, (p == 2) ? ar : aw, (p == 2) ? rv : dw});
    end
    rd_val = rv;
    addr_wr_i = aw; wdata_wr_i = dw; addr_rd_i = ar;
    req_wr_i = 1'b1; req_rd_i = 1'b1; req_cr_i = 1'b0;
    cnt = 0; cyc = 0; rd_seen = 0;
    while (cnt < nt && cyc < nt * 40) begin
      @(negedge clk);
      cyc++;
      if (ack_o) begin
        cnt++;
        if (gnt_o[2]) rd_seen++;
        if (cnt == nt) drop_port(3'b111);
      end
    end
    chk("hold_ack_count", cnt, nt);
    chk("hold_rd_grants", rd_seen, rd_exp);
    drop_port(3'b111);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, hit;
    Reset = 1'b1;
    req_wr_i = 1'b0; req_cr_i = 1'b0; req_rd_i = 1'b0;
    addr_wr_i = 8'h00; wdata_wr_i = 8'h00;
    addr_cr_i = 8'h00; wdata_cr_i = 8'h00; addr_rd_i = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'({cs_n_o, wr_n_o, rd_n_o, a_d_o, ad_oe_o, gnt_o, ack_o, busy_o}),
        32'(10'b1111_0_000_00));
    chk("reset_data", 32'({ad_out_o, rdata_o}), 32'd0);
    Reset = 1'b0;

    // Reset in the middle of a write data strobe.
    @(negedge clk);
    req_wr_i = 1'b1; addr_wr_i = 8'h11; wdata_wr_i = 8'h99;
    cyc = 0;
    while (gnt_o == 3'b000 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_test_grant", 32'(gnt_o), 32'(3'b001));
    repeat (5 * PH + 1) @(negedge clk);
    chk("rst_test_in_data_stb", 32'({wr_n_o, a_d_o, ad_out_o}), 32'({1'b0, 1'b1, 8'h99}));
    #2 Reset = 1'b1;
    #1 chk("rst_async_outputs", 32'({cs_n_o, wr_n_o, ad_oe_o, gnt_o, ack_o, busy_o}),
           32'({1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0}));
    req_wr_i = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    hit = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack_o || gnt_o != 3'b000) hit++;
    end
    chk("rst_no_ack_after", hit, 0);

    sb_en = 1'b1;
    @(negedge clk);
    run_round(3'b001, 1'b0, 8'h21, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00);
    run_round(3'b100, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h37);
    run_round(3'b111, 1'b0, 8'h31, 8'hA1, 8'h32, 8'hA2, 8'h33, 8'hC3);
    run_round(3'b010, 1'b1, 8'h00, 8'h00, 8'h41, 8'h4B, 8'h00, 8'h00);
    run_round(3'b110, 1'b1, 8'h00, 8'h00, 8'h51, 8'h5B, 8'h52, 8'h6C);
    for (int i = 0; i < 20; i++) begin
      run_round(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom));
    end
    run_hold(10);

    chk("queue_drained", exp_q.size(), 0);
    chk("idle_bus_quiet", idle_bad, 0);
    chk("rd_n_implies_no_oe", proto_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
